// File: rtl/lag_credit_channel_if.sv
// Credit-based channel bundle: forward flits, backward credit pulses, and credit/error status.
// The sender/receiver side uses master; the channel uses slave.
interface lag_credit_channel_if #(
    parameter int unsigned nPC   = 1,
    parameter int unsigned FlitW = 32,
    parameter int unsigned CW    = 3
);
    logic [nPC-1:0][FlitW-1:0] data_in;
    logic [nPC-1:0]            valid_in;
    logic [nPC-1:0]            credit_avail;
    logic [nPC-1:0][FlitW-1:0] data_out;
    logic [nPC-1:0]            valid_out;
    logic [nPC-1:0]            credit_in;
    logic [nPC-1:0][CW-1:0]    credit_cnt;
    logic [nPC-1:0]            err_underflow;
    logic [nPC-1:0]            err_overflow;

    modport master (
        output data_in, valid_in, credit_in,
        input  credit_avail, data_out, valid_out, credit_cnt, err_underflow, err_overflow
    );

    modport slave (
        input  data_in, valid_in, credit_in,
        output credit_avail, data_out, valid_out, credit_cnt, err_underflow, err_overflow
    );
endinterface

// File: rtl/lag_credit_channel.sv
// Pipelined multi-PC link with a pipelined credit-return path and a per-PC sender credit counter.
// Flits without a credit are dropped at the input and flagged; excess credits are flagged.
module lag_credit_channel #(
    parameter int unsigned stages        = 2,
    parameter int unsigned credit_stages = 2,
    parameter int unsigned nPC           = 1,
    parameter int unsigned buf_depth     = 4,
    parameter int unsigned FlitW         = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    lag_credit_channel_if.slave ch
);
    localparam int unsigned CW = $clog2(buf_depth + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(buf_depth);

    logic [nPC-1:0]         send;
    logic [nPC-1:0]         avail;
    logic [nPC-1:0]         cr_ret;
    logic [nPC-1:0][CW-1:0] cnt_q, cnt_d;
    logic [nPC-1:0]         unf_q, unf_d;
    logic [nPC-1:0]         ovf_q, ovf_d;

    always_comb begin
        avail = '0;
        for (int p = 0; p < nPC; p++) begin
            avail[p] = (cnt_q[p] != '0);
        end
    end

    assign send = ch.valid_in & avail;

    generate
        if (stages == 0) begin : g_data_comb
            assign ch.data_out  = ch.data_in;
            assign ch.valid_out = send;
        end else begin : g_data_pipe
            logic [nPC-1:0][FlitW-1:0] data_q [stages];
            logic [nPC-1:0]            valid_q[stages];

            // Data loads every cycle; only the valid bit gates meaning downstream.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < stages; k++) begin
                        data_q[k]  <= '0;
                        valid_q[k] <= '0;
                    end
                end else begin
                    data_q[0]  <= ch.data_in;
                    valid_q[0] <= send;
                    for (int unsigned k = 1; k < stages; k++) begin
                        data_q[k]  <= data_q[k-1];
                        valid_q[k] <= valid_q[k-1];
                    end
                end
            end

            assign ch.data_out  = data_q[stages-1];
            assign ch.valid_out = valid_q[stages-1];
        end

        if (credit_stages == 0) begin : g_cred_comb
            assign cr_ret = ch.credit_in;
        end else begin : g_cred_pipe
            logic [nPC-1:0] cr_q[credit_stages];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < credit_stages; k++) begin
                        cr_q[k] <= '0;
                    end
                end else begin
                    cr_q[0] <= ch.credit_in;
                    for (int unsigned k = 1; k < credit_stages; k++) begin
                        cr_q[k] <= cr_q[k-1];
                    end
                end
            end

            assign cr_ret = cr_q[credit_stages-1];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        unf_d = unf_q;
        ovf_d = ovf_q;
        for (int p = 0; p < nPC; p++) begin
            if (ch.valid_in[p] && !avail[p]) begin
                unf_d[p] = 1'b1;
            end
            if (send[p] && !cr_ret[p]) begin
                cnt_d[p] = cnt_q[p] - CW'(1);
            end else if (!send[p] && cr_ret[p]) begin
                // Saturate at the buffer depth; a credit beyond it is a receiver bug.
                if (cnt_q[p] == MaxCnt) begin
                    ovf_d[p] = 1'b1;
                end else begin
                    cnt_d[p] = cnt_q[p] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {nPC{MaxCnt}};
            unf_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            unf_q <= unf_d;
            ovf_q <= ovf_d;
        end
    end

    assign ch.credit_avail  = avail;
    assign ch.credit_cnt    = cnt_q;
    assign ch.err_underflow = unf_q;
    assign ch.err_overflow  = ovf_q;
endmodule

// File: tb/tb_lag_credit_channel.sv
// Directed bench: a 3-stage/2-credit-stage two-PC channel driven from a vector table,
// plus hand-written sequences for a zero-stage channel and a mid-operation reset.
module tb_lag_credit_channel;
    logic clk;
    logic rst_n;

    lag_credit_channel_if #(.nPC(2), .FlitW(8), .CW(3)) ch_a ();
    lag_credit_channel_if #(.nPC(1), .FlitW(8), .CW(3)) ch_z ();

    lag_credit_channel #(
        .stages(3), .credit_stages(2), .nPC(2), .buf_depth(4), .FlitW(8)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ch    (ch_a)
    );

    lag_credit_channel #(
        .stages(0), .credit_stages(0), .nPC(1), .buf_depth(4), .FlitW(8)
    ) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .ch    (ch_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] vi;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] ci;
        logic [1:0] vo;
        logic [7:0] q0;
        logic [7:0] q1;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [1:0] av;
        logic [1:0] eu;
        logic [1:0] eo;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // {valid_out, data_out[1], data_out[0], cnt[1], cnt[0], avail, err_u, err_o}
    function automatic logic [63:0] snap_a();
        return 64'({ch_a.valid_out, ch_a.data_out[1], ch_a.data_out[0],
                    ch_a.credit_cnt[1], ch_a.credit_cnt[0], ch_a.credit_avail,
                    ch_a.err_underflow, ch_a.err_overflow});
    endfunction

    function automatic logic [63:0] exp_a(input vec_t v);
        return 64'({v.vo, v.q1, v.q0, v.c1, v.c0, v.av, v.eu, v.eo});
    endfunction

    // {valid_out, data_out, cnt, avail, err_u, err_o}
    function automatic logic [63:0] snap_z();
        return 64'({ch_z.valid_out, ch_z.data_out[0], ch_z.credit_cnt[0], ch_z.credit_avail,
                    ch_z.err_underflow, ch_z.err_overflow});
    endfunction

    task automatic add(input logic [1:0] vi, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] ci, input logic [1:0] vo, input logic [7:0] q0,
                       input logic [7:0] q1, input logic [2:0] c0, input logic [2:0] c1,
                       input logic [1:0] av, input logic [1:0] eu, input logic [1:0] eo);
        vec_t v;
        v = '{vi, d0, d1, ci, vo, q0, q1, c0, c1, av, eu, eo};
        vecs.push_back(v);
    endtask

    task automatic idle_a();
        ch_a.valid_in  = '0;
        ch_a.data_in   = '0;
        ch_a.credit_in = '0;
    endtask

    initial begin
        vec_t v;
        // Outputs at row r show the flit driven at row r-2 (third edge) and credits from r-2.
        //   vi     d0     d1     ci     vo     q0     q1     c0 c1 av     eu     eo
        add(2'b01, 8'hA5, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 4, 2'b11, 2'b00, 2'b00); // r0
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 4, 2'b11, 2'b00, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5, 8'h00, 3, 4, 2'b11, 2'b00, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 4, 2'b11, 2'b00, 2'b00);
        add(2'b10, 8'h00, 8'h11, 2'b00, 2'b00, 8'h00, 8'h00, 3, 3, 2'b11, 2'b00, 2'b00); // r4
        add(2'b10, 8'h00, 8'h12, 2'b00, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b00, 2'b00);
        add(2'b10, 8'h00, 8'h13, 2'b00, 2'b10, 8'h00, 8'h11, 3, 1, 2'b11, 2'b00, 2'b00);
        add(2'b10, 8'h00, 8'h14, 2'b00, 2'b10, 8'h00, 8'h12, 3, 0, 2'b01, 2'b00, 2'b00);
        add(2'b10, 8'h00, 8'h15, 2'b00, 2'b10, 8'h00, 8'h13, 3, 0, 2'b01, 2'b10, 2'b00); // r8
        add(2'b10, 8'h00, 8'h16, 2'b00, 2'b10, 8'h00, 8'h14, 3, 0, 2'b01, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h15, 3, 0, 2'b01, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h16, 3, 0, 2'b01, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00, 3, 0, 2'b01, 2'b10, 2'b00); // r12
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 0, 2'b01, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 1, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00, 3, 1, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 1, 2'b11, 2'b10, 2'b00); // r16
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00);
        add(2'b10, 8'h00, 8'h21, 2'b00, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00); // r20
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 8'h21, 3, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 3, 2, 2'b11, 2'b10, 2'b00); // r24
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00, 4, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 2, 2'b11, 2'b10, 2'b00);
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 2, 2'b11, 2'b10, 2'b01); // r28
        add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 2, 2'b11, 2'b10, 2'b01);

        rst_n = 1'b0;
        idle_a();
        ch_z.valid_in  = '0;
        ch_z.data_in   = '0;
        ch_z.credit_in = '0;
        step();
        step();
        chk("reset_a", snap_a(), exp_a('{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00,
                                         3'd4, 3'd4, 2'b11, 2'b00, 2'b00}));
        chk("reset_z", snap_z(), 64'({1'b0, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0}));
        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            ch_a.valid_in   = v.vi;
            ch_a.data_in[0] = v.d0;
            ch_a.data_in[1] = v.d1;
            ch_a.credit_in  = v.ci;
            step();
            chk($sformatf("row%0d", i), snap_a(), exp_a(v));
        end
        idle_a();

        // Zero-stage channel: outputs follow data_in/send combinationally.
        ch_z.valid_in   = 1'b1;
        ch_z.data_in[0] = 8'h3C;
        #1;
        chk("z_pass", snap_z(), 64'({1'b1, 8'h3C, 3'd4, 1'b1, 1'b0, 1'b0}));
        for (int i = 0; i < 4; i++) step();
        chk("z_empty_block", snap_z(), 64'({1'b0, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b0}));
        step();
        chk("z_underflow", snap_z(), 64'({1'b0, 8'h3C, 3'd0, 1'b0, 1'b1, 1'b0}));
        ch_z.valid_in  = 1'b0;
        ch_z.credit_in = 1'b1;
        step();
        ch_z.credit_in = 1'b0;
        chk("z_credit_next_edge", snap_z(), 64'({1'b0, 8'h3C, 3'd1, 1'b1, 1'b1, 1'b0}));

        // Mid-operation reset: three flits in flight on PC0 with one credit left.
        for (int i = 0; i < 3; i++) begin
            ch_a.valid_in   = 2'b01;
            ch_a.data_in[0] = 8'hE1 + 8'(i);
            step();
        end
        idle_a();
        chk("pre_reset", snap_a(), exp_a('{2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 8'hE1, 8'h00,
                                           3'd1, 3'd2, 2'b11, 2'b10, 2'b01}));
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", snap_a(), exp_a('{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00,
                                             3'd4, 3'd4, 2'b11, 2'b00, 2'b00}));
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_reset%0d", i), snap_a(),
                exp_a('{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00,
                        3'd4, 3'd4, 2'b11, 2'b00, 2'b00}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/lag_credit_channel.md
Name: LAG_credit_channel

Overview:
- Parametrised successor to the plain pipelined channel.
- Carries nPC physical channels of flit_t through `stages` register stages, with a per-PC valid bit pipelined alongside the data.
- Pipelines the receiver's credit-return pulses back through `credit_stages` registers, so each flit costs one credit.
- Keeps a per-PC sender-side credit counter, exports a send-permission flag and flags protocol violations. Sits between a router output port and the downstream router input buffers.

Parameters:
- stages, 2: data/valid register stages, 0..8; 0 = combinational pass-through.
- credit_stages, 2: credit-return register stages, 0..8; 0 = credit_in applied directly.
- nPC, 1: physical channels per trunk, 1..8.
- buf_depth, 4: downstream flit buffer depth per PC, 1..255; this is also the initial credit count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  flit_t[nPC]  flits from the sender.
- valid_in  in  nPC  flit valid per PC.
- credit_avail  out  nPC  1 = PC has at least one credit; the sender may assert valid_in.
- data_out  out  flit_t[nPC]  flits delivered to the receiver.
- valid_out  out  nPC  delivered flit valid.
- credit_in  in  nPC  one-cycle pulse from the receiver per freed buffer slot.
- credit_cnt  out  nPC x CW  current credit count, CW = $clog2(buf_depth+1).
- err_underflow  out  nPC  sticky: valid_in seen with zero credits.
- err_overflow  out  nPC  sticky: credit returned while the count is already buf_depth.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - all data stage registers to '0 and all valid stage registers to 0.
  - all credit-return registers to 0.
  - credit_cnt to buf_depth on every PC.
  - err_* to 0.
  - Outputs follow immediately: valid_out=0, data_out='0 (stages>0), credit_avail=all 1s.
- Reset asserted mid-operation: in-flight flits and credits are discarded with no drain. After release, counting restarts at buf_depth.
- Accept, per PC p:
  - send[p] = valid_in[p] & (credit_cnt[p]!=0).
  - Only send[p] enters the valid pipeline. A valid_in with credit_cnt==0 is dropped (valid 0 enters the pipe) and sets err_underflow[p].
- Data path:
  - Stage 0 captures {send, data_in}; stage k captures stage k-1.
  - data_out/valid_out = last stage, so latency = stages cycles exactly.
  - A data register loads every cycle regardless of valid; no enables, no back-pressure inside the channel.
  - stages=0: data_out=data_in, valid_out=send (combinational).
- Credit path: cr_ret[p] = credit_in[p] delayed credit_stages cycles, single-bit shift register per PC. credit_stages=0 means cr_ret=credit_in.
- Counter update, per PC, every clock edge:
  - send & !cr_ret: cnt-1.
  - !send & cr_ret: cnt+1, saturating at buf_depth. If cnt==buf_depth, the count holds and err_overflow[p] is set.
  - send & cr_ret, simultaneous: cnt unchanged.
  - neither: hold.
- credit_avail[p] = (credit_cnt[p]!=0), decoded combinationally from the registered count. A credit consumed in cycle t is reflected in cycle t+1.
- Width rule: CW-bit unsigned arithmetic. Underflow below 0 is impossible by construction (send requires cnt!=0).
- PCs are fully independent; no cross-PC arbitration or shared state.
- err_* clear only on reset.
- Round-trip sustainable throughput per PC = min(1, buf_depth/(stages+credit_stages+receiver turnaround)). The channel itself imposes no bubbles.

Test Plan:
- Reset/latency: stages=3, nPC=2, buf_depth=4. After reset: credit_cnt=4, credit_avail=2'b11, valid_out=0. Drive valid_in[0] with data A at cycle 10 -> valid_out[0]=1 with data_out[0]=A at cycle 13 only; credit_cnt[0]=3 at cycle 11.
- Credit exhaustion: buf_depth=4, no credit_in, valid_in[1]=1 for 6 cycles -> 4 flits delivered. credit_avail[1]=0 after the 4th accept; flits 5-6 dropped; err_underflow[1]=1; err_overflow=0.
- Credit return latency: credit_stages=2, cnt=0. Pulse credit_in[0] at cycle 20 -> credit_cnt[0]=1 and credit_avail[0]=1 at cycle 23 (2 stages plus the counter register).
- Simultaneous events: cnt=2, send and delayed credit in the same cycle -> cnt stays 2. Extra credit pulse at cnt=buf_depth=4 -> cnt stays 4, err_overflow=1.
- Zero-stage mode: stages=0, credit_stages=0 -> data_out/valid_out equal data_in/send in the same cycle. A credit_in pulse increments cnt on the next edge.
- Mid-operation reset: 3 flits in flight and cnt=1, assert rst_n=0 asynchronously between edges -> valid_out=0 and credit_cnt=buf_depth immediately. No stale flit appears after release.
